// File: rtl/knight_pkg.sv
// Shared constants for the knight movement and animation blocks: status codes,
// animation state encoding, sprite ROM bases, screen bounds and small helpers.
package knight_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_WALK   = 4'd1;
  localparam logic [3:0] ST_JUMP   = 4'd2;
  localparam logic [3:0] ST_FALL   = 4'd3;
  localparam logic [3:0] ST_ATTACK = 4'd4;

  typedef enum logic [2:0] {
    A_IDLE   = 3'd0,
    A_WALK   = 3'd1,
    A_JUMP   = 3'd2,
    A_FALL   = 3'd3,
    A_ATTACK = 3'd4
  } anim_state_e;

  localparam logic [4:0] SPR_IDLE = 5'd0;
  localparam logic [4:0] SPR_WALK = 5'd2;
  localparam logic [4:0] SPR_JUMP = 5'd6;
  localparam logic [4:0] SPR_FALL = 5'd7;
  localparam logic [4:0] SPR_ATK  = 5'd8;
  localparam logic [4:0] SPR_ATK2 = 5'd11;

  localparam logic [9:0] SCREEN_X_MAX = 10'd639;
  localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

  // Attack (4) and unknown codes land on IDLE; attack entry is decided separately.
  function automatic anim_state_e status_to_state(input logic [3:0] st);
    case (st)
      ST_WALK: return A_WALK;
      ST_JUMP: return A_JUMP;
      ST_FALL: return A_FALL;
      default: return A_IDLE;
    endcase
  endfunction

  function automatic logic [4:0] sprite_base(input anim_state_e s, input logic second);
    case (s)
      A_WALK:   return SPR_WALK;
      A_JUMP:   return SPR_JUMP;
      A_FALL:   return SPR_FALL;
      A_ATTACK: return second ? SPR_ATK2 : SPR_ATK;
      default:  return SPR_IDLE;
    endcase
  endfunction

  function automatic logic [9:0] clamp_coord(input logic signed [10:0] v,
                                             input logic [9:0] max_v);
    if (v < 11'sd0)
      return 10'd0;
    else if (v > $signed({1'b0, max_v}))
      return max_v;
    else
      return v[9:0];
  endfunction

endpackage

// File: rtl/anim_hitbox_calc.sv
// Combinational attack hitbox: a reach-long box ahead of the body edge on the
// facing side, height centred on PlayerY, clamped to the visible screen.
module anim_hitbox_calc
  import knight_pkg::*;
#(
  parameter int ATK_REACH  = 40,
  parameter int ATK_HEIGHT = 40
) (
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] Player_Size_X,
  input  logic       face_left,
  output logic [9:0] x0,
  output logic [9:0] x1,
  output logic [9:0] y0,
  output logic [9:0] y1
);

  localparam logic signed [10:0] REACH  = 11'(ATK_REACH);
  localparam logic signed [10:0] HALF_H = 11'(ATK_HEIGHT / 2);

  logic signed [10:0] half;
  logic signed [10:0] cx;
  logic signed [10:0] cy;
  logic signed [10:0] ax0;
  logic signed [10:0] ax1;

  always_comb begin
    half = $signed({1'b0, Player_Size_X}) >>> 1;
    cx   = $signed({1'b0, PlayerX});
    cy   = $signed({1'b0, PlayerY});
    if (face_left) begin
      ax1 = cx - half;
      ax0 = ax1 - REACH;
    end else begin
      ax0 = cx + half;
      ax1 = ax0 + REACH;
    end
    x0 = clamp_coord(ax0, SCREEN_X_MAX);
    x1 = clamp_coord(ax1, SCREEN_X_MAX);
    y0 = clamp_coord(cy - HALF_H, SCREEN_Y_MAX);
    y1 = clamp_coord(cy + HALF_H, SCREEN_Y_MAX);
  end

endmodule

// File: rtl/knight_anim_seq.sv
// Per-frame knight animation sequencer with committed attacks and hitbox.
// Define KNIGHT_ANIM_COMBO_EN to allow one chained follow-up attack.
module knight_anim_seq
  import knight_pkg::*;
#(
  parameter int IDLE_FRAMES  = 2,
  parameter int IDLE_HOLD    = 16,
  parameter int WALK_FRAMES  = 4,
  parameter int WALK_HOLD    = 6,
  parameter int ATK_FRAMES   = 3,
  parameter int ATK_HOLD     = 4,
  parameter int ATK_COOLDOWN = 8,
  parameter int ATK_REACH    = 40,
  parameter int ATK_HEIGHT   = 40
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [3:0] Player_Status,
  input  logic       Inverse,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] Player_Size_X,
  output logic [2:0] anim_state,
  output logic [2:0] anim_frame,
  output logic [4:0] sprite_id,
  output logic       flip,
  output logic       attack_start,
  output logic       attack_active,
  output logic [9:0] hit_x0,
  output logic [9:0] hit_x1,
  output logic [9:0] hit_y0,
  output logic [9:0] hit_y1
);

`ifdef KNIGHT_ANIM_COMBO_EN
  localparam bit COMBO_EN = 1'b1;
`else
  localparam bit COMBO_EN = 1'b0;
`endif

  localparam logic [7:0] IDLE_HOLD_M1  = 8'(IDLE_HOLD - 1);
  localparam logic [7:0] WALK_HOLD_M1  = 8'(WALK_HOLD - 1);
  localparam logic [7:0] ATK_HOLD_M1   = 8'(ATK_HOLD - 1);
  localparam logic [2:0] IDLE_LAST     = 3'(IDLE_FRAMES - 1);
  localparam logic [2:0] WALK_LAST     = 3'(WALK_FRAMES - 1);
  localparam logic [2:0] ATK_LAST      = 3'(ATK_FRAMES - 1);
  localparam logic [7:0] COOLDOWN_INIT = 8'(ATK_COOLDOWN);

  anim_state_e state_q, state_d, next_base;
  logic [2:0]  frame_q, frame_d, frame_last;
  logic [7:0]  hold_q, hold_d, hold_m1;
  logic [7:0]  cooldown_q, cooldown_d;
  logic        flip_q, flip_d;
  logic        combo_q, combo_d;
  logic        start_q, start_d;
  logic        active_q, active_d;
  logic [4:0]  sprite_q, sprite_d;
  logic [9:0]  hx0_q, hx1_q, hy0_q, hy1_q;
  logic [9:0]  calc_x0, calc_x1, calc_y0, calc_y1;

  always_comb begin
    next_base  = status_to_state(Player_Status);
    state_d    = state_q;
    frame_d    = frame_q;
    hold_d     = hold_q;
    cooldown_d = (cooldown_q != 8'd0) ? cooldown_q - 8'd1 : 8'd0;
    combo_d    = combo_q;
    start_d    = 1'b0;
    flip_d     = Inverse;

    // JUMP/FALL use a zero limit so they sit on frame 0 with hold 0.
    case (state_q)
      A_IDLE:   begin hold_m1 = IDLE_HOLD_M1; frame_last = IDLE_LAST; end
      A_WALK:   begin hold_m1 = WALK_HOLD_M1; frame_last = WALK_LAST; end
      A_ATTACK: begin hold_m1 = ATK_HOLD_M1;  frame_last = ATK_LAST;  end
      default:  begin hold_m1 = 8'd0;         frame_last = 3'd0;      end
    endcase

    if (state_q == A_ATTACK) begin
      flip_d = flip_q;
      if (hold_q != hold_m1) begin
        hold_d = hold_q + 8'd1;
      end else begin
        hold_d = 8'd0;
        if (frame_q != frame_last) begin
          frame_d = frame_q + 3'd1;
        end else if (COMBO_EN && (Player_Status == ST_ATTACK) && !combo_q) begin
          frame_d = 3'd0;
          combo_d = 1'b1;
          start_d = 1'b1;
          flip_d  = Inverse;
        end else begin
          state_d    = next_base;
          frame_d    = 3'd0;
          combo_d    = 1'b0;
          cooldown_d = COOLDOWN_INIT;
          flip_d     = Inverse;
        end
      end
    end else if ((Player_Status == ST_ATTACK) && (cooldown_q == 8'd0)) begin
      state_d = A_ATTACK;
      frame_d = 3'd0;
      hold_d  = 8'd0;
      start_d = 1'b1;
    end else if (next_base != state_q) begin
      state_d = next_base;
      frame_d = 3'd0;
      hold_d  = 8'd0;
    end else if (hold_q != hold_m1) begin
      hold_d = hold_q + 8'd1;
    end else begin
      hold_d  = 8'd0;
      frame_d = (frame_q == frame_last) ? 3'd0 : frame_q + 3'd1;
    end

    sprite_d = sprite_base(state_d, combo_d) + {2'b00, frame_d};
    active_d = (state_d == A_ATTACK) && (frame_d != 3'd0);
  end

  anim_hitbox_calc #(
    .ATK_REACH (ATK_REACH),
    .ATK_HEIGHT(ATK_HEIGHT)
  ) u_hitbox (
    .PlayerX      (PlayerX),
    .PlayerY      (PlayerY),
    .Player_Size_X(Player_Size_X),
    .face_left    (flip_d),
    .x0           (calc_x0),
    .x1           (calc_x1),
    .y0           (calc_y0),
    .y1           (calc_y1)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= A_IDLE;
      frame_q    <= 3'd0;
      hold_q     <= 8'd0;
      cooldown_q <= 8'd0;
      flip_q     <= 1'b0;
      combo_q    <= 1'b0;
      start_q    <= 1'b0;
      active_q   <= 1'b0;
      sprite_q   <= 5'd0;
      hx0_q      <= 10'd0;
      hx1_q      <= 10'd0;
      hy0_q      <= 10'd0;
      hy1_q      <= 10'd0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
      cooldown_q <= cooldown_d;
      flip_q     <= flip_d;
      combo_q    <= combo_d;
      start_q    <= start_d;
      active_q   <= active_d;
      sprite_q   <= sprite_d;
      hx0_q      <= active_d ? calc_x0 : 10'd0;
      hx1_q      <= active_d ? calc_x1 : 10'd0;
      hy0_q      <= active_d ? calc_y0 : 10'd0;
      hy1_q      <= active_d ? calc_y1 : 10'd0;
    end
  end

  assign anim_state    = state_q;
  assign anim_frame    = frame_q;
  assign sprite_id     = sprite_q;
  assign flip          = flip_q;
  assign attack_start  = start_q;
  assign attack_active = active_q;
  assign hit_x0        = hx0_q;
  assign hit_x1        = hx1_q;
  assign hit_y0        = hy0_q;
  assign hit_y1        = hy1_q;

endmodule
